// File: rtl/indicator_scan.sv
// Multiplexed common-anode hex indicator: per-digit value/control registers,
// scan timebase with one dead cycle per digit slot, and a blink phase.
module indicator_scan #(
    parameter int ID_W      = 2,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 100,
    localparam int DIGITS   = 2**ID_W
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  wr,
    input  logic                  wr_ctl,
    input  logic [3:0]            Data,
    input  logic [ID_W-1:0]       PortID,
    output logic [4*DIGITS-1:0]   Indicator,
    output logic [6:0]            Seg,
    output logic                  Dp,
    output logic [DIGITS-1:0]     Anode
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int RND_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [3:0]      r_value [DIGITS];
    logic [2:0]      r_ctl   [DIGITS];
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_idx;
    logic [RND_W-1:0] r_rnd;
    logic             r_ph;

    logic [3:0]        w_digit;
    logic [2:0]        w_ctl;
    logic              w_vis;
    logic [6:0]        w_dec;
    logic [DIGITS-1:0] w_anode;
    logic              w_slot_end;
    logic              w_frame_end;

    assign w_digit     = r_value[r_idx];
    assign w_ctl       = r_ctl[r_idx];
    assign w_vis       = !w_ctl[0] && !(w_ctl[1] && r_ph);
    assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == ID_W'(DIGITS - 1));

    always_comb begin
        Indicator = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            Indicator[4*k +: 4] = r_value[k];
        end
    end

    // Segment order {g,f,e,d,c,b,a}, active-low.
    always_comb begin
        w_dec = 7'h7F;
        case (w_digit)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            4'hF: w_dec = 7'h0E;
            default: w_dec = 7'h7F;
        endcase
    end

    // cnt==0 is the dead cycle between digits: no anode enabled.
    always_comb begin
        w_anode = '1;
        if (r_cnt != '0) begin
            w_anode[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                r_value[k] <= '0;
                r_ctl[k]   <= '0;
            end
            r_cnt <= '0;
            r_idx <= '0;
            r_rnd <= '0;
            r_ph  <= 1'b0;
            Seg   <= 7'h7F;
            Dp    <= 1'b1;
            Anode <= '1;
        end else begin
            if (wr) begin
                r_value[PortID] <= Data;
            end
            if (wr_ctl) begin
                r_ctl[PortID] <= Data[2:0];
            end

            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + ID_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_frame_end) begin
                if (r_rnd == RND_W'(BLINK_DIV - 1)) begin
                    r_rnd <= '0;
                    r_ph  <= ~r_ph;
                end else begin
                    r_rnd <= r_rnd + RND_W'(1);
                end
            end

            Seg   <= w_vis ? w_dec : 7'h7F;
            Dp    <= w_vis ? ~w_ctl[2] : 1'b1;
            Anode <= w_anode;
        end
    end

endmodule

// File: tb/tb_indicator_scan.sv
// Self-checking bench for indicator_scan; expectations come from a
// time-since-reset model of the scan plus shadow copies of value/ctl.
module tb_indicator_scan;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        wr;
    logic        wr_ctl;
    logic [3:0]  Data;
    logic [1:0]  PortID;
    logic [15:0] Indicator;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  Anode;

    indicator_scan #(.ID_W(2), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .wr        (wr),
        .wr_ctl    (wr_ctl),
        .Data      (Data),
        .PortID    (PortID),
        .Indicator (Indicator),
        .Seg       (Seg),
        .Dp        (Dp),
        .Anode     (Anode)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned s       = 0;
    logic [3:0]  m_val   [ND];
    logic [2:0]  m_ctl   [ND];
    logic [6:0]  dec_tab [16];
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_anode;

    function automatic logic [15:0] exp_ind();
        return {m_val[3], m_val[2], m_val[1], m_val[0]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < ND; k++) begin
            m_val[k] = '0;
            m_ctl[k] = '0;
        end
        s = 0;
    endtask

    // s = clock edges since reset release before this edge; pins after the
    // edge reflect the scan position and registers as they were before it.
    task automatic step();
        int unsigned cnt, idx;
        bit ph, vis;
        cnt = s % SD;
        idx = (s / SD) % ND;
        ph  = ((s / (SD * ND * BD)) % 2) == 1;
        vis = !m_ctl[idx][0] && !(m_ctl[idx][1] && ph);
        exp_anode = (cnt == 0) ? 4'hF : (4'hF ^ (4'h1 << idx));
        exp_seg   = vis ? dec_tab[m_val[idx]] : 7'h7F;
        exp_dp    = vis ? ~m_ctl[idx][2] : 1'b1;
        if (wr)     m_val[PortID] = Data;
        if (wr_ctl) m_ctl[PortID] = Data[2:0];
        @(posedge clk);
        #1;
        s++;
        wr     = 1'b0;
        wr_ctl = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; wr = 1'b0; wr_ctl = 1'b0; Data = '0; PortID = '0;
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b1;
        model_clear();
        #2;
        if (Seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", Seg); else n_pass++;
        n_total++;
        if (Dp !== 1'b1) $display("FAIL reset_dp got %b want 1", Dp); else n_pass++;
        n_total++;
        if (Anode !== 4'hF) $display("FAIL reset_anode got %b want 1111", Anode); else n_pass++;
        n_total++;
        if (Indicator !== 16'h0) $display("FAIL reset_ind got %h want 0000", Indicator); else n_pass++;
        n_total++;
    endtask

    task automatic test_writes();
        for (int k = 0; k < ND; k++) begin
            wr = 1'b1; PortID = 2'(k); Data = 4'(k + 1);
            step();
            if (Indicator !== exp_ind()) $display("FAIL wr_ind got %h want %h", Indicator, exp_ind()); else n_pass++;
            n_total++;
            if (Anode !== exp_anode) $display("FAIL wr_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
        end
        if (Indicator !== 16'h4321) $display("FAIL wr_ind_4321 got %h want 4321", Indicator); else n_pass++;
        n_total++;
    endtask

    task automatic test_scan_frame();
        for (int c = 0; c < 2 * SD * ND; c++) begin
            step();
            if (Anode !== exp_anode) $display("FAIL scan_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
            if (Seg !== exp_seg) $display("FAIL scan_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (Dp !== exp_dp) $display("FAIL scan_dp s=%0d got %b want %b", s, Dp, exp_dp); else n_pass++;
            n_total++;
            if (((s - 1) % SD) == 0) begin
                if (Anode !== 4'hF) $display("FAIL dead_time s=%0d got %b want 1111", s, Anode); else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_blank();
        wr_ctl = 1'b1; PortID = 2'd2; Data = 4'b0001;
        step();
        if (Indicator !== 16'h4321) $display("FAIL blank_ind got %h want 4321", Indicator); else n_pass++;
        n_total++;
        for (int c = 0; c < SD * ND; c++) begin
            step();
            if (Anode !== exp_anode) $display("FAIL blank_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
            if (Seg !== exp_seg) $display("FAIL blank_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (Dp !== exp_dp) $display("FAIL blank_dp s=%0d got %b want %b", s, Dp, exp_dp); else n_pass++;
            n_total++;
            if (Anode === 4'b1011 && Seg !== 7'h7F) $display("FAIL blank_dark got %h want 7f", Seg); else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_blink();
        wr_ctl = 1'b1; PortID = 2'd1; Data = 4'b0110;
        step();
        for (int c = 0; c < 4 * SD * ND * BD; c++) begin
            step();
            if (Anode !== exp_anode) $display("FAIL blink_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
            if (Seg !== exp_seg) $display("FAIL blink_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (Dp !== exp_dp) $display("FAIL blink_dp s=%0d got %b want %b", s, Dp, exp_dp); else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_both();
        wr = 1'b1; wr_ctl = 1'b1; PortID = 2'd3; Data = 4'hF;
        step();
        if (Indicator[15:12] !== 4'hF) $display("FAIL both_val got %h want f", Indicator[15:12]); else n_pass++;
        n_total++;
        for (int c = 0; c < SD * ND; c++) begin
            step();
            if (Seg !== exp_seg) $display("FAIL both_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (Dp !== exp_dp) $display("FAIL both_dp s=%0d got %b want %b", s, Dp, exp_dp); else n_pass++;
            n_total++;
            if (Anode === 4'b0111 && (Seg !== 7'h7F || Dp !== 1'b1)) $display("FAIL both_blank got %h/%b want 7f/1", Seg, Dp); else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr     = ($urandom_range(0, 3) == 0);
            wr_ctl = ($urandom_range(0, 4) == 0);
            PortID = 2'($urandom_range(0, 3));
            Data   = 4'($urandom_range(0, 15));
            step();
            if (Indicator !== exp_ind()) $display("FAIL rand_ind s=%0d got %h want %h", s, Indicator, exp_ind()); else n_pass++;
            n_total++;
            if (Anode !== exp_anode) $display("FAIL rand_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
            if (Seg !== exp_seg) $display("FAIL rand_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (Dp !== exp_dp) $display("FAIL rand_dp s=%0d got %b want %b", s, Dp, exp_dp); else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < SD * ND; c++) begin
            if ((s % (SD * ND)) == 2 * SD + 1) break;
            step();
        end
        #2;
        Reset = 1'b0;
        #1;
        if (Seg !== 7'h7F) $display("FAIL rstmid_seg got %h want 7f", Seg); else n_pass++;
        n_total++;
        if (Dp !== 1'b1) $display("FAIL rstmid_dp got %b want 1", Dp); else n_pass++;
        n_total++;
        if (Anode !== 4'hF) $display("FAIL rstmid_anode got %b want 1111", Anode); else n_pass++;
        n_total++;
        if (Indicator !== 16'h0) $display("FAIL rstmid_ind got %h want 0000", Indicator); else n_pass++;
        n_total++;
        @(posedge clk);
        #1;
        Reset = 1'b1;
        model_clear();
        for (int c = 0; c < 2 * SD * ND; c++) begin
            step();
            if (Anode !== exp_anode) $display("FAIL rstmid_scan_anode s=%0d got %b want %b", s, Anode, exp_anode); else n_pass++;
            n_total++;
            if (Seg !== exp_seg) $display("FAIL rstmid_scan_seg s=%0d got %h want %h", s, Seg, exp_seg); else n_pass++;
            n_total++;
            if (s == 2) begin
                if (Anode !== 4'b1110) $display("FAIL rstmid_digit0 got %b want 1110", Anode); else n_pass++;
                n_total++;
            end
        end
    endtask

    initial begin
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
        dec_tab[12] = 7'h46; dec_tab[13] = 7'h21; dec_tab[14] = 7'h06; dec_tab[15] = 7'h0E;
        test_reset();
        test_writes();
        test_scan_frame();
        test_blank();
        test_blink();
        test_both();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
